// File: rtl/branch_resolve_unit.sv
// Branch resolution: carries predictor metadata ID->EX->MEM, trains the PHT and redirects fetch on mispredict.
// Optional resolved/mispredict counters are enabled with `define BRANCH_STATS_EN.
module branch_resolve_unit #(
    parameter int unsigned PHT_IDX_W = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic                 id_valid_i,
    input  logic                 id_is_branch_i,
    input  logic                 id_predict_btaken_i,
    input  logic [PHT_IDX_W-1:0] id_pht_idx_i,
    input  logic [31:0]          id_q_pc_i,
    input  logic                 ex_actual_taken_i,
    input  logic [31:0]          ex_target_i,
    output logic                 mem_q_is_branch,
    output logic                 mem_q_jump_taken,
    output logic [PHT_IDX_W-1:0] mem_q_pht_idx,
    output logic                 redirect_valid_o,
    output logic [31:0]          redirect_pc_o,
    output logic                 flush_younger_o,
    output logic [31:0]          branch_count_o,
    output logic [31:0]          mispredict_count_o
);

    logic                 ex_valid, ex_is_branch, ex_pred;
    logic [PHT_IDX_W-1:0] ex_pht_idx;
    logic [31:0]          ex_pc;

    logic                 mem_valid, mem_is_branch, mem_pred, mem_actual;
    logic [PHT_IDX_W-1:0] mem_pht_idx;
    logic [31:0]          mem_pc, mem_target;

    logic train, mispredict;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ex_valid      <= 1'b0;
            ex_is_branch  <= 1'b0;
            ex_pred       <= 1'b0;
            ex_pht_idx    <= '0;
            ex_pc         <= '0;
            mem_valid     <= 1'b0;
            mem_is_branch <= 1'b0;
            mem_pred      <= 1'b0;
            mem_actual    <= 1'b0;
            mem_pht_idx   <= '0;
            mem_pc        <= '0;
            mem_target    <= '0;
        end else if (flush_i) begin
            ex_valid  <= 1'b0;
            mem_valid <= 1'b0;
        end else if (!stall_i) begin
            // A redirect this cycle means both younger slots are wrong-path.
            ex_valid      <= id_valid_i & ~mispredict;
            ex_is_branch  <= id_is_branch_i;
            ex_pred       <= id_predict_btaken_i;
            ex_pht_idx    <= id_pht_idx_i;
            ex_pc         <= id_q_pc_i;
            mem_valid     <= ex_valid & ~mispredict;
            mem_is_branch <= ex_is_branch;
            mem_pred      <= ex_pred;
            mem_actual    <= ex_actual_taken_i;
            mem_pht_idx   <= ex_pht_idx;
            mem_pc        <= ex_pc;
            mem_target    <= ex_target_i;
        end
    end

    always_comb begin
        train      = mem_valid & mem_is_branch & ~stall_i & ~flush_i;
        mispredict = train & (mem_actual != mem_pred);

        mem_q_is_branch  = train;
        mem_q_jump_taken = train & mem_actual;
        mem_q_pht_idx    = train ? mem_pht_idx : '0;
        redirect_valid_o = mispredict;
        flush_younger_o  = mispredict;
        redirect_pc_o    = '0;
        if (mispredict) begin
            redirect_pc_o = mem_actual ? mem_target : mem_pc + 32'd4;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] branch_cnt_q, mispredict_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            if (train && branch_cnt_q != '1) begin
                branch_cnt_q <= branch_cnt_q + 32'd1;
            end
            if (mispredict && mispredict_cnt_q != '1) begin
                mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
            end
        end
    end

    assign branch_count_o     = branch_cnt_q;
    assign mispredict_count_o = mispredict_cnt_q;
`else
    assign branch_count_o     = '0;
    assign mispredict_count_o = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: training pulse, redirect, stall, flush, reset and stats.
module tb_branch_resolve_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        stall_i, flush_i;
    logic        id_valid_i, id_is_branch_i, id_predict_btaken_i;
    logic [5:0]  id_pht_idx_i;
    logic [31:0] id_q_pc_i;
    logic        ex_actual_taken_i;
    logic [31:0] ex_target_i;
    logic        mem_q_is_branch, mem_q_jump_taken;
    logic [5:0]  mem_q_pht_idx;
    logic        redirect_valid_o, flush_younger_o;
    logic [31:0] redirect_pc_o, branch_count_o, mispredict_count_o;

    int unsigned total = 0;
    int unsigned bad   = 0;

`ifdef BRANCH_STATS_EN
    localparam logic [31:0] EXP_BR = 32'd5;
    localparam logic [31:0] EXP_MP = 32'd2;
`else
    localparam logic [31:0] EXP_BR = 32'd0;
    localparam logic [31:0] EXP_MP = 32'd0;
`endif

    branch_resolve_unit #(.PHT_IDX_W(6)) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .stall_i             (stall_i),
        .flush_i             (flush_i),
        .id_valid_i          (id_valid_i),
        .id_is_branch_i      (id_is_branch_i),
        .id_predict_btaken_i (id_predict_btaken_i),
        .id_pht_idx_i        (id_pht_idx_i),
        .id_q_pc_i           (id_q_pc_i),
        .ex_actual_taken_i   (ex_actual_taken_i),
        .ex_target_i         (ex_target_i),
        .mem_q_is_branch     (mem_q_is_branch),
        .mem_q_jump_taken    (mem_q_jump_taken),
        .mem_q_pht_idx       (mem_q_pht_idx),
        .redirect_valid_o    (redirect_valid_o),
        .redirect_pc_o       (redirect_pc_o),
        .flush_younger_o     (flush_younger_o),
        .branch_count_o      (branch_count_o),
        .mispredict_count_o  (mispredict_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [31:0] isb, input logic [31:0] jt,
                             input logic [31:0] idx, input logic [31:0] rv, input logic [31:0] rpc);
        @(negedge clk_i);
        check({tag, ".is_branch"}, 32'(mem_q_is_branch), isb);
        check({tag, ".taken"},     32'(mem_q_jump_taken), jt);
        check({tag, ".pht_idx"},   32'(mem_q_pht_idx), idx);
        check({tag, ".redirect"},  32'(redirect_valid_o), rv);
        check({tag, ".redir_pc"},  redirect_pc_o, rpc);
        check({tag, ".flush_yng"}, 32'(flush_younger_o), rv);
    endtask

    task automatic check_idle(input string tag);
        check_out(tag, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic issue(input logic [31:0] pc, input logic pred, input logic [5:0] idx);
        id_valid_i          = 1'b1;
        id_is_branch_i      = 1'b1;
        id_predict_btaken_i = pred;
        id_pht_idx_i        = idx;
        id_q_pc_i           = pc;
    endtask

    task automatic clear_id;
        id_valid_i          = 1'b0;
        id_is_branch_i      = 1'b0;
        id_predict_btaken_i = 1'b0;
        id_pht_idx_i        = '0;
        id_q_pc_i           = '0;
    endtask

    // Returns with the branch sitting in MEM, before that cycle's negedge.
    task automatic send(input logic [31:0] pc, input logic pred, input logic [5:0] idx,
                        input logic act, input logic [31:0] tgt);
        issue(pc, pred, idx);
        tick;
        clear_id;
        ex_actual_taken_i = act;
        ex_target_i       = tgt;
        tick;
        ex_actual_taken_i = 1'b0;
        ex_target_i       = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst_ni = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        clear_id;
        ex_actual_taken_i = 1'b0; ex_target_i = '0;
        tick; tick;
        rst_ni = 1'b1;
        check_idle("reset");
        check("reset.br_cnt", branch_count_o, 32'd0);
        check("reset.mp_cnt", mispredict_count_o, 32'd0);
        tick;

        // correct prediction, checked in EX cycle then MEM cycle
        issue(32'h100, 1'b1, 6'h2A);
        tick;
        clear_id;
        ex_actual_taken_i = 1'b1; ex_target_i = 32'h400;
        check_idle("t1_ex");
        tick;
        ex_actual_taken_i = 1'b0; ex_target_i = '0;
        check_out("t1_mem", 32'd1, 32'd1, 32'h2A, 32'd0, 32'd0);
        tick;
        check_idle("t1_after");

        // not-taken mispredict kills the branch behind it
        issue(32'h200, 1'b1, 6'h15);
        tick;
        issue(32'h204, 1'b0, 6'h05);
        ex_actual_taken_i = 1'b0; ex_target_i = 32'h300;
        tick;
        clear_id;
        ex_actual_taken_i = 1'b1;
        check_out("t2_mem", 32'd1, 32'd0, 32'h15, 32'd1, 32'h204);
        tick;
        ex_actual_taken_i = 1'b0; ex_target_i = '0;
        check_idle("t2_younger");
        tick;
        check_idle("t2_after");

        // taken mispredict at top of memory, then not-taken wrap
        send(32'hFFFF_FFFC, 1'b0, 6'h3F, 1'b1, 32'h80);
        check_out("t3_taken", 32'd1, 32'd1, 32'h3F, 32'd1, 32'h80);
        tick;
        send(32'hFFFF_FFFC, 1'b1, 6'h01, 1'b0, 32'h80);
        check_out("t3_wrap", 32'd1, 32'd0, 32'h01, 32'd1, 32'h0);
        tick;

        // stall in MEM holds the mispredict for 3 cycles
        send(32'h300, 1'b0, 6'h11, 1'b1, 32'h500);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_idle("t4_stall");
            tick;
        end
        stall_i = 1'b0;
        check_out("t4_release", 32'd1, 32'd1, 32'h11, 32'd1, 32'h500);
        tick;
        check_idle("t4_once");
        tick;

        // flush beats a mispredict in MEM and kills the branch in EX
        issue(32'h400, 1'b1, 6'h22);
        tick;
        issue(32'h408, 1'b1, 6'h23);
        ex_actual_taken_i = 1'b0; ex_target_i = 32'h900;
        tick;
        clear_id;
        ex_actual_taken_i = 1'b0;
        flush_i = 1'b1;
        check_idle("t5_flush");
        tick;
        flush_i = 1'b0;
        check_idle("t5_empty");
        tick;

        // reset with two branches in flight
        issue(32'h500, 1'b1, 6'h30);
        tick;
        issue(32'h504, 1'b0, 6'h31);
        ex_actual_taken_i = 1'b0;
        rst_ni = 1'b0;
        tick;
        rst_ni = 1'b1;
        clear_id;
        ex_actual_taken_i = 1'b1;
        check_idle("t6_rst");
        check("t6_rst.br_cnt", branch_count_o, 32'd0);
        check("t6_rst.mp_cnt", mispredict_count_o, 32'd0);
        tick;
        ex_actual_taken_i = 1'b0;
        check_idle("t6_rst2");
        tick;

        // back-to-back correct branches pulse on consecutive cycles
        issue(32'h600, 1'b1, 6'h01);
        tick;
        issue(32'h700, 1'b0, 6'h02);
        ex_actual_taken_i = 1'b1;
        tick;
        clear_id;
        ex_actual_taken_i = 1'b0;
        check_out("t7_a", 32'd1, 32'd1, 32'h01, 32'd0, 32'd0);
        tick;
        check_out("t7_b", 32'd1, 32'd0, 32'h02, 32'd0, 32'd0);
        tick;
        check_idle("t7_after");

        // three more: two mispredicts, one correct (5 branches / 2 mispredicts since reset)
        send(32'h800, 1'b1, 6'h04, 1'b0, 32'h0);
        check_out("t8_a", 32'd1, 32'd0, 32'h04, 32'd1, 32'h804);
        tick;
        send(32'h900, 1'b0, 6'h05, 1'b1, 32'hA00);
        check_out("t8_b", 32'd1, 32'd1, 32'h05, 32'd1, 32'hA00);
        tick;
        send(32'hA00, 1'b1, 6'h06, 1'b1, 32'hB00);
        check_out("t8_c", 32'd1, 32'd1, 32'h06, 32'd0, 32'd0);
        tick;
        @(negedge clk_i);
        check("stats.br_cnt", branch_count_o, EXP_BR);
        check("stats.mp_cnt", mispredict_count_o, EXP_MP);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

- Carries branch-prediction metadata from the decode-stage predictor through EX to MEM.
- Compares the predicted direction with the outcome computed in EX.
- In MEM, emits the one-cycle predictor training pulse (`mem_q_is_branch`, `mem_q_jump_taken`, `mem_q_pht_idx`) and, on a mispredict, a front-end redirect plus a flush of younger stages.
- Sits between the decode-stage direction predictor and the fetch PC mux.

## Interface
Parameters:
- `PHT_IDX_W`, default 6: width of the pattern-history index carried with each branch.

Ports (clock and reset first):
- `clk_i`  in  1  core clock; all state updates on rising edge.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `stall_i`  in  1  freezes the ID/EX and EX/MEM registers; suppresses all MEM-stage pulses.
- `flush_i`  in  1  external flush (trap/exception); kills EX and MEM contents.
- `id_valid_i`  in  1  decode slot holds a real instruction.
- `id_is_branch_i`  in  1  instruction is a conditional branch.
- `id_predict_btaken_i`  in  1  predictor direction.
- `id_pht_idx_i`  in  `PHT_IDX_W`  predictor index used for the lookup.
- `id_q_pc_i`  in  32  instruction PC.
- `ex_actual_taken_i`  in  1  branch outcome from the EX comparator; valid for the instruction in EX.
- `ex_target_i`  in  32  taken-path target computed in EX.
- `mem_q_is_branch`  out  1  predictor training strobe.
- `mem_q_jump_taken`  out  1  actual direction for training.
- `mem_q_pht_idx`  out  `PHT_IDX_W`  index to train.
- `redirect_valid_o`  out  1  front end must fetch from `redirect_pc_o` next cycle.
- `redirect_pc_o`  out  32  corrected fetch PC.
- `flush_younger_o`  out  1  kill IF/ID contents (equals `redirect_valid_o`).
- `branch_count_o`  out  32  resolved-branch count (see Configuration).
- `mispredict_count_o`  out  32  mispredict count (see Configuration).

## Operation
- Two register stages.
  - ID/EX holds `{valid, is_branch, pred, pht_idx, pc}`.
  - EX/MEM holds `{valid, is_branch, pred, actual, pht_idx, pc, target}`.
- When `stall_i`=0:
  - ID/EX captures the ID inputs.
  - EX/MEM captures ID/EX plus `ex_actual_taken_i` and `ex_target_i`.
- When `stall_i`=1: both registers hold.
- MEM stage, gated by `mem_valid & mem_is_branch & !stall_i`:
  - `mem_q_is_branch` = 1.
  - `mem_q_jump_taken` = actual.
  - `mem_q_pht_idx` = stored index.
- Mispredict = gated MEM branch with `actual != pred`.
  - Asserts `redirect_valid_o` and `flush_younger_o`.
  - `redirect_pc_o` = target if actual = 1, else `pc + 32'd4` (modulo 2^32; 0xFFFFFFFC wraps to 0x00000000).
- Redirect kill: in the cycle a redirect is asserted, the next edge loads both registers with `valid` = 0.
  - EX/MEM does not take the wrong-path EX instruction.
  - ID/EX does not take the wrong-path ID instruction.
- `flush_i`=1: next edge clears `valid` in both registers, regardless of `stall_i`.
  - MEM pulses are suppressed in that same cycle: all pulse outputs are ANDed with `!flush_i`.
- Non-branch valid instructions flow through with `is_branch` = 0 and produce no pulse.
- Outputs while idle: `mem_q_*` = 0, `redirect_valid_o` = 0, `redirect_pc_o` = 0, `flush_younger_o` = 0.
  - `mem_q_pht_idx` and `redirect_pc_o` are forced to 0 whenever their strobe is low.

## Timing
- Reset (`rst_ni`=0 at an edge) clears every `valid`, `is_branch`, `pred`, `actual` and all stored fields to 0; all outputs read 0 the cycle after.
  - Reset dominates `stall_i` and `flush_i`.
  - Reset mid-operation discards in-flight branches with no training pulse.
- Latency: a branch present in ID at edge N is in EX during cycle N+1 and in MEM during cycle N+2. Outputs for it are combinational from EX/MEM in cycle N+2, extended by any stall cycles.
- Each branch produces exactly one training pulse, and at most one redirect, on the first non-stalled, non-flushed cycle it occupies MEM.
- `stall_i` and redirect in the same cycle: the redirect is suppressed and the registers hold; the redirect fires once the stall releases.
- `flush_i` and redirect in the same cycle: `flush_i` wins, with no redirect and no pulse.
- Back-to-back branches: a mispredict on the older branch kills the younger one, which never pulses. Two correct branches give pulses on consecutive cycles.

## Configuration
- `BRANCH_STATS_EN` defined:
  - `branch_count_o` increments on every `mem_q_is_branch` pulse.
  - `mispredict_count_o` increments on every `redirect_valid_o`.
  - Both counters are 32-bit, saturate at 0xFFFFFFFF, and reset to 0.
- `BRANCH_STATS_EN` undefined: both outputs are tied to 0 and no counter flops exist.

## Test plan
- Correct prediction: branch at PC 0x100, pred=1, actual=1, idx=0x2A → cycle N+2: `mem_q_is_branch`=1, `mem_q_jump_taken`=1, `mem_q_pht_idx`=0x2A, `redirect_valid_o`=0.
- Not-taken mispredict: PC 0x200, pred=1, actual=0 → `redirect_pc_o`=0x204, `flush_younger_o`=1. The branch entering behind it at PC 0x204 gives no pulse.
- Taken mispredict with wrap: PC 0xFFFFFFFC, pred=0, actual=1, target 0x80 → `redirect_pc_o`=0x80. Same PC with pred=1, actual=0 → `redirect_pc_o`=0x0.
- Stall in MEM: mispredicting branch in MEM with `stall_i` high 3 cycles → no pulses for 3 cycles, then exactly one pulse and one redirect.
- Flush vs reset:
  - `flush_i` with a mispredict in MEM → no redirect or pulse; the pipeline is empty the next cycle.
  - `rst_ni`=0 with two branches in flight → all outputs 0 and no pulses afterwards.
- Stats (`BRANCH_STATS_EN`): 5 branches with 2 mispredicts → `branch_count_o`=5, `mispredict_count_o`=2. Without the macro, both outputs read 0.
